// File: rtl/rom_sin_pkg.sv
// Shared constants and types for the sine ROM and the logic that reads it.
`timescale 1ns/1ps
package rom_sin_pkg;

  localparam int ROM_ADDR_WIDTH = 10;
  localparam int ROM_DATA_WIDTH = 12;
  localparam int ROM_RD_LATENCY = 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rom_sin_owner_pipe.sv
// Delay line of {valid, owner} that tags each ROM read until its data emerges.
`timescale 1ns/1ps
module rom_sin_owner_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_vld,
  input  logic i_owner,
  output logic o_vld,
  output logic o_owner
);

  logic [DEPTH-1:0] r_vld;
  logic [DEPTH-1:0] r_owner;

  if (DEPTH == 1) begin : g_single
    // Single stage: capture the accept tag for one cycle.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_vld   <= 1'b0;
        r_owner <= 1'b0;
      end else begin
        r_vld   <= i_vld;
        r_owner <= i_owner;
      end
    end
  end else begin : g_shift
    // Multi-stage shift toward the tail at bit DEPTH-1.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_vld   <= '0;
        r_owner <= '0;
      end else begin
        r_vld   <= {r_vld[DEPTH-2:0], i_vld};
        r_owner <= {r_owner[DEPTH-2:0], i_owner};
      end
    end
  end

  assign o_vld   = r_vld[DEPTH-1];
  assign o_owner = r_owner[DEPTH-1];

endmodule

// File: rtl/rom_sin_arb.sv
// Round-robin arbiter sharing the single-port sine ROM between the DDS (port 0)
// and the FFT twiddle fetch (port 1), with a port-1 burst lock.
`timescale 1ns/1ps
module rom_sin_arb
  import rom_sin_pkg::*;
#(
  parameter int ADDR_WIDTH = ROM_ADDR_WIDTH,
  parameter int DATA_WIDTH = ROM_DATA_WIDTH,
  parameter int RD_LATENCY = ROM_RD_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  output logic                  gnt0,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic                  rvld0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic                  gnt1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  rvld1,
  input  logic                  lock1,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_rdata
);

  arb_state_t            r_state;
  arb_state_t            w_state_nxt;
  logic                  r_last_gnt;
  logic [ADDR_WIDTH-1:0] r_rom_addr;
  logic                  w_locked;
  logic                  w_accept;
  logic                  w_tail_vld;
  logic                  w_tail_owner;
  logic                  r_rvld0;
  logic                  r_rvld1;
  logic [DATA_WIDTH-1:0] r_rdata0;
  logic [DATA_WIDTH-1:0] r_rdata1;

  // Grant decision; a dropped lock1 releases port 0 in the very same cycle.
  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    w_locked = (r_state == LOCKED) && lock1;
    if (!rst_n) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end else if (w_locked) begin
      gnt1 = req1;
    end else if (req0 && req1) begin
      gnt0 = r_last_gnt;
      gnt1 = !r_last_gnt;
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

  assign w_accept = gnt0 || gnt1;

  // Lock state transitions.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (gnt1 && lock1) w_state_nxt = LOCKED;
        else               w_state_nxt = IDLE;
      end
      LOCKED: begin
        if (!lock1) w_state_nxt = IDLE;
        else        w_state_nxt = LOCKED;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // ROM address follows the granted port, otherwise the last granted address.
  always_comb begin
    if (gnt0)      rom_addr = addr0;
    else if (gnt1) rom_addr = addr1;
    else           rom_addr = r_rom_addr;
  end

  // Arbiter state, round-robin pointer and held ROM address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_last_gnt <= 1'b1;
      r_rom_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_last_gnt <= gnt1;
        r_rom_addr <= rom_addr;
      end
    end
  end

  rom_sin_owner_pipe #(
    .DEPTH(RD_LATENCY)
  ) u_owner_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_vld  (w_accept),
    .i_owner(gnt1),
    .o_vld  (w_tail_vld),
    .o_owner(w_tail_owner)
  );

  // Return registers: steer ROM data to the owner of the read at the tail.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rvld0  <= 1'b0;
      r_rvld1  <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_rvld0 <= w_tail_vld && !w_tail_owner;
      r_rvld1 <= w_tail_vld && w_tail_owner;
      if (w_tail_vld && !w_tail_owner) r_rdata0 <= rom_rdata;
      if (w_tail_vld && w_tail_owner)  r_rdata1 <= rom_rdata;
    end
  end

  assign rvld0  = r_rvld0;
  assign rvld1  = r_rvld1;
  assign rdata0 = r_rdata0;
  assign rdata1 = r_rdata1;

endmodule

// File: tb/tb_rom_sin_arb.sv
// Directed bench: two arbiters (ROM latency 1 and 2) driven in lockstep, each
// in front of a behavioural sine ROM.
`timescale 1ns/1ps
module tb_rom_sin_arb;
  import rom_sin_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, lock1;
  logic [9:0]  addr0, addr1;
  logic        gnt0_a, gnt1_a, rvld0_a, rvld1_a, gnt0_b, gnt1_b, rvld0_b, rvld1_b;
  logic [11:0] rdata0_a, rdata1_a, rdata0_b, rdata1_b;
  logic [9:0]  rom_addr_a, rom_addr_b;
  logic [11:0] rom_q_a, rom_q_b1, rom_q_b;
  logic [11:0] rom_tbl [1024];

  bit          exp_v [2][2][2048];
  bit   [11:0] exp_d [2][2][2048];
  bit   [11:0] hold  [2][2];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  rom_sin_arb #(.RD_LATENCY(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .addr0(addr0), .gnt0(gnt0_a), .rdata0(rdata0_a), .rvld0(rvld0_a),
    .req1(req1), .addr1(addr1), .gnt1(gnt1_a), .rdata1(rdata1_a), .rvld1(rvld1_a),
    .lock1(lock1), .rom_addr(rom_addr_a), .rom_rdata(rom_q_a)
  );

  rom_sin_arb #(.RD_LATENCY(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .addr0(addr0), .gnt0(gnt0_b), .rdata0(rdata0_b), .rvld0(rvld0_b),
    .req1(req1), .addr1(addr1), .gnt1(gnt1_b), .rdata1(rdata1_b), .rvld1(rvld1_b),
    .lock1(lock1), .rom_addr(rom_addr_b), .rom_rdata(rom_q_b)
  );

  always_ff @(posedge clk) begin
    rom_q_a  <= rom_tbl[rom_addr_a];
    rom_q_b1 <= rom_tbl[rom_addr_b];
    rom_q_b  <= rom_q_b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic sched(input int p, input int a);
    exp_v[0][p][cyc+2] = 1'b1;
    exp_d[0][p][cyc+2] = rom_tbl[a];
    exp_v[1][p][cyc+3] = 1'b1;
    exp_d[1][p][cyc+3] = rom_tbl[a];
  endtask

  // One cycle: drive inputs mid-cycle, check grants and returned data.
  task automatic step(input logic rst, input logic r0, input int a0, input logic r1,
                      input int a1, input logic lk, input logic eg0, input logic eg1);
    logic        rv [2][2];
    logic [11:0] rd [2][2];
    @(negedge clk);
    rst_n = rst; req0 = r0; addr0 = 10'(a0); req1 = r1; addr1 = 10'(a1); lock1 = lk;
    #1;
    check_eq("gnt0_l1", 32'(gnt0_a), 32'(eg0));
    check_eq("gnt1_l1", 32'(gnt1_a), 32'(eg1));
    check_eq("gnt0_l2", 32'(gnt0_b), 32'(eg0));
    check_eq("gnt1_l2", 32'(gnt1_b), 32'(eg1));
    if (eg0) sched(0, a0);
    if (eg1) sched(1, a1);
    rv[0][0] = rvld0_a; rv[0][1] = rvld1_a; rv[1][0] = rvld0_b; rv[1][1] = rvld1_b;
    rd[0][0] = rdata0_a; rd[0][1] = rdata1_a; rd[1][0] = rdata0_b; rd[1][1] = rdata1_b;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        if (exp_v[d][p][cyc]) hold[d][p] = exp_d[d][p][cyc];
        check_eq($sformatf("rvld%0d_l%0d", p, d + 1), 32'(rv[d][p]), 32'(exp_v[d][p][cyc]));
        check_eq($sformatf("rdata%0d_l%0d", p, d + 1), 32'(rd[d][p]), 32'(hold[d][p]));
      end
    end
    // A reset edge at the end of this cycle discards everything still in flight.
    if (!rst) begin
      for (int i = 1; i < 5; i++)
        for (int d = 0; d < 2; d++)
          for (int p = 0; p < 2; p++) exp_v[d][p][cyc+i] = 1'b0;
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < 2; p++) hold[d][p] = 12'd0;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs();
    check_eq("rom_addr_rst_l1", 32'(rom_addr_a), 32'd0);
    check_eq("rom_addr_rst_l2", 32'(rom_addr_b), 32'd0);
    check_eq("state_rst_l1", 32'(dut_a.r_state), 32'd0);
    check_eq("state_rst_l2", 32'(dut_b.r_state), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 1024; i++)
      rom_tbl[i] = 12'($rtoi(2048.0 + 2047.0 * $sin(6.283185307179586 * real'(i) / 1024.0)));
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0; addr0 = 10'd0; addr1 = 10'd0;
    repeat (3) @(negedge clk);

    // Out of reset: all outputs zero, then idle.
    idle(1);
    check_reset_outputs();
    idle(1);

    // Contention: port 0 first, then strict alternation.
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b1, 16, 1'b1, 256, 1'b0, (i % 2) == 0, (i % 2) == 1);
    idle(3);

    // Sole requester sweeps the whole table back to back, wrapping at the end.
    for (int k = 0; k < 1024; k++) step(1'b1, 1'b1, k, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    idle(3);

    // Lock burst: port 1 wins (last grant was 0) and keeps the ROM for 8 reads.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 100, 1'b1, i, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 100, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    idle(3);

    // Lock held with port 1 idle stalls port 0; release grants it the same cycle.
    step(1'b1, 1'b1, 200, 1'b1, 500, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 200, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 200, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    idle(3);

    // Reset with reads in flight on both ports.
    step(1'b1, 1'b1, 40, 1'b1, 300, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 40, 1'b1, 300, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 40, 1'b1, 300, 1'b1, 1'b0, 1'b0);
    idle(1);
    check_reset_outputs();
    idle(3);
    step(1'b1, 1'b1, 1023, 1'b1, 512, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1023, 1'b1, 512, 1'b0, 1'b0, 1'b1);
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
